id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one clock, clk, and one synchronous active-high reset, reset; no other clocks or asynchronous paths.
REQ-002 Ports SHALL be (name direction width meaning), in this order:
- clk  in  1  pipeline clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  5 each  source register numbers
- id_Write_register  in  5  destination register
- id_RegWrite, id_MemRead  in  1 each  control bits
- id_ctrl  in  16  remaining EX/MEM control, passed through
- id_imm  in  32  extended immediate
- Read_data1, Read_data2  in  32 each  register file outputs for id_rs/id_rt
- ex_result  in  32  ALU output of the instruction currently held here (combinational)
- mem_RegWrite  in  1; mem_Write_register  in  5; mem_result  in  32  MEM-stage writeback candidate
- wb_RegWrite  in  1; wb_Write_register  in  5; wb_Write_data  in  32  WB-stage write
- flush  in  1  branch/jump redirect; kill ID instruction
- hold  in  1  downstream freeze
- ex_valid, ex_RegWrite, ex_MemRead  out  1 each
- ex_rs, ex_rt, ex_Write_register  out  5 each
- ex_ctrl  out  16; ex_imm  out  32
- ex_op1, ex_op2  out  32 each  forwarded operands
- stall  out  1  load-use interlock; freezes PC and IF/ID
- stall_count  out  16  saturating load-use stall counter

Function
REQ-003 Forwarding SHALL select, per operand, the first match: ex (ex_valid & ex_RegWrite & !ex_MemRead & ex_Write_register==src) -> ex_result; mem (mem_RegWrite & mem_Write_register==src) -> mem_result; wb (wb_RegWrite & wb_Write_register==src) -> wb_Write_data; else Read_dataN.
REQ-004 Source register 0 SHALL always yield 32'h00000000 and never match a forward.
REQ-005 stall SHALL be combinational 1 iff id_valid & ex_valid & ex_MemRead & ex_Write_register!=0 & (ex_Write_register==id_rs | ex_Write_register==id_rt) & !flush.
REQ-006 Update priority at posedge: reset > flush > hold > stall > load.
REQ-007 flush: next state SHALL be a bubble (ex_valid, ex_RegWrite, ex_MemRead = 0; other fields don't-care but zeroed), even with hold=1.
REQ-008 hold (no flush): all outputs SHALL keep their values; stall_count SHALL NOT increment.
REQ-009 stall (no flush/hold): insert bubble; stall_count increments by 1, saturating at 16'hFFFF.
REQ-010 load: capture all id_* fields and forwarded operands; ex_valid=id_valid; ex_RegWrite/ex_MemRead gated by id_valid.
REQ-011 Latency SHALL be one cycle ID->EX; a load-use pair SHALL cost exactly one bubble, the load's data then arriving via mem_result.
REQ-012 ex_Write_register==0 SHALL never enable ex forwarding even with ex_RegWrite=1.

Reset
REQ-013 Synchronous reset SHALL clear every output register and stall_count to 0; stall SHALL read 0 during the cycle after reset.
REQ-014 Reset asserted mid-hold or mid-stall SHALL override both.

Structure
REQ-015 The shared pipeline package SHALL hold the 16-bit ctrl-field width and the zero-register constant.
REQ-016 One sub-module, operand_forward (combinational per-operand select), SHALL be instantiated twice; all state lives in id_ex_stage.

Verification
REQ-017 ALU chain: add $3 in EX (ex_result=0x10), ID reads $3 (RF=0x5) -> ex_op1=0x10 next cycle.
REQ-018 Priority: ex, mem and wb all writing $4 (0x1/0x2/0x3) -> captures 0x1; ex off -> 0x2; both off -> 0x3.
REQ-019 Load-use: lw $2 in EX, ID uses $2 -> stall=1 one cycle, bubble, stall_count=1; next cycle op from mem_result=0xAB.
REQ-020 flush with hold=1 and stall=1 -> bubble, stall_count unchanged.
REQ-021 $0 source with all forwards targeting $0 and RF=0xFFFFFFFF -> operand 0.
REQ-022 Reset during hold with valid contents -> all outputs 0 next cycle; 65536 stalls -> stall_count=0xFFFF.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX pipeline definitions.
// Field widths, the zero register and the ID/EX bundle.
package id_ex_stage_pkg;

  localparam int CTRL_W = 16;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        wr;
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       imm;
    logic [31:0]       op1;
    logic [31:0]       op2;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_operand_forward.sv
// Per-operand bypass select for the ID/EX stage.
// Nearest producer wins; $0 always reads zero.
module operand_forward
  import id_ex_stage_pkg::*;
(
  input  logic [4:0]  src,
  input  logic [31:0] rf_data,
  input  logic        ex_en,
  input  logic [4:0]  ex_wr,
  input  logic [31:0] ex_result,
  input  logic        mem_en,
  input  logic [4:0]  mem_wr,
  input  logic [31:0] mem_result,
  input  logic        wb_en,
  input  logic [4:0]  wb_wr,
  input  logic [31:0] wb_data,
  output logic [31:0] op
);

  // priority select: ex > mem > wb > register file
  always_comb begin
    op = rf_data;
    if (src == REG_ZERO)
      op = 32'h0;
    else if (ex_en && ex_wr == src)
      op = ex_result;
    else if (mem_en && mem_wr == src)
      op = mem_result;
    else if (wb_en && wb_wr == src)
      op = wb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding
// and load-use interlock.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_Write_register,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       id_imm,
  input  logic [31:0]       Read_data1,
  input  logic [31:0]       Read_data2,
  input  logic [31:0]       ex_result,
  input  logic              mem_RegWrite,
  input  logic [4:0]        mem_Write_register,
  input  logic [31:0]       mem_result,
  input  logic              wb_RegWrite,
  input  logic [4:0]        wb_Write_register,
  input  logic [31:0]       wb_Write_data,
  input  logic              flush,
  input  logic              hold,
  output logic              ex_valid,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_Write_register,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_imm,
  output logic [31:0]       ex_op1,
  output logic [31:0]       ex_op2,
  output logic              stall,
  output logic [15:0]       stall_count
);

  id_ex_t      q;
  id_ex_t      d;
  logic [15:0] stall_cnt;
  logic        ex_fwd;
  logic [31:0] fwd1;
  logic [31:0] fwd2;

  // a load in EX cannot bypass; its data comes from MEM later
  assign ex_fwd = q.valid & q.reg_write & ~q.mem_read;

  operand_forward u_fwd1 (
    .src        (id_rs),
    .rf_data    (Read_data1),
    .ex_en      (ex_fwd),
    .ex_wr      (q.wr),
    .ex_result  (ex_result),
    .mem_en     (mem_RegWrite),
    .mem_wr     (mem_Write_register),
    .mem_result (mem_result),
    .wb_en      (wb_RegWrite),
    .wb_wr      (wb_Write_register),
    .wb_data    (wb_Write_data),
    .op         (fwd1)
  );

  operand_forward u_fwd2 (
    .src        (id_rt),
    .rf_data    (Read_data2),
    .ex_en      (ex_fwd),
    .ex_wr      (q.wr),
    .ex_result  (ex_result),
    .mem_en     (mem_RegWrite),
    .mem_wr     (mem_Write_register),
    .mem_result (mem_result),
    .wb_en      (wb_RegWrite),
    .wb_wr      (wb_Write_register),
    .wb_data    (wb_Write_data),
    .op         (fwd2)
  );

  assign stall = id_valid & q.valid & q.mem_read
               & (q.wr != REG_ZERO)
               & ((q.wr == id_rs) | (q.wr == id_rt))
               & ~flush;

  // next-state bundle for a normal load
  always_comb begin
    d           = '0;
    d.valid     = id_valid;
    d.reg_write = id_valid & id_RegWrite;
    d.mem_read  = id_valid & id_MemRead;
    d.rs        = id_rs;
    d.rt        = id_rt;
    d.wr        = id_Write_register;
    d.ctrl      = id_ctrl;
    d.imm       = id_imm;
    d.op1       = fwd1;
    d.op2       = fwd2;
  end

  // reset > flush > hold > stall > load
  always_ff @(posedge clk) begin
    if (reset) begin
      q         <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (hold) begin
      q <= q;
    end else if (stall) begin
      q <= '0;
      if (stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 16'd1;
    end else begin
      q <= d;
    end
  end

  assign ex_valid          = q.valid;
  assign ex_RegWrite       = q.reg_write;
  assign ex_MemRead        = q.mem_read;
  assign ex_rs             = q.rs;
  assign ex_rt             = q.rt;
  assign ex_Write_register = q.wr;
  assign ex_ctrl           = q.ctrl;
  assign ex_imm            = q.imm;
  assign ex_op1            = q.op1;
  assign ex_op2            = q.op2;
  assign stall_count       = stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage.
// Expected EX state is queued, then popped after each edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_Write_register;
  logic        id_RegWrite;
  logic        id_MemRead;
  logic [15:0] id_ctrl;
  logic [31:0] id_imm;
  logic [31:0] Read_data1;
  logic [31:0] Read_data2;
  logic [31:0] ex_result;
  logic        mem_RegWrite;
  logic [4:0]  mem_Write_register;
  logic [31:0] mem_result;
  logic        wb_RegWrite;
  logic [4:0]  wb_Write_register;
  logic [31:0] wb_Write_data;
  logic        flush;
  logic        hold;
  logic        ex_valid;
  logic        ex_RegWrite;
  logic        ex_MemRead;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_Write_register;
  logic [15:0] ex_ctrl;
  logic [31:0] ex_imm;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic        stall;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk                (clk),
    .reset              (reset),
    .id_valid           (id_valid),
    .id_rs              (id_rs),
    .id_rt              (id_rt),
    .id_Write_register  (id_Write_register),
    .id_RegWrite        (id_RegWrite),
    .id_MemRead         (id_MemRead),
    .id_ctrl            (id_ctrl),
    .id_imm             (id_imm),
    .Read_data1         (Read_data1),
    .Read_data2         (Read_data2),
    .ex_result          (ex_result),
    .mem_RegWrite       (mem_RegWrite),
    .mem_Write_register (mem_Write_register),
    .mem_result         (mem_result),
    .wb_RegWrite        (wb_RegWrite),
    .wb_Write_register  (wb_Write_register),
    .wb_Write_data      (wb_Write_data),
    .flush              (flush),
    .hold               (hold),
    .ex_valid           (ex_valid),
    .ex_RegWrite        (ex_RegWrite),
    .ex_MemRead         (ex_MemRead),
    .ex_rs              (ex_rs),
    .ex_rt              (ex_rt),
    .ex_Write_register  (ex_Write_register),
    .ex_ctrl            (ex_ctrl),
    .ex_imm             (ex_imm),
    .ex_op1             (ex_op1),
    .ex_op2             (ex_op2),
    .stall              (stall),
    .stall_count        (stall_count)
  );

  typedef struct {
    string       tag;
    logic        v;
    logic        rw;
    logic        mr;
    logic [4:0]  wr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 0; flush = 0; hold = 0;
    id_valid = 0; id_rs = 0; id_rt = 0;
    id_Write_register = 0;
    id_RegWrite = 0; id_MemRead = 0;
    id_ctrl = 0; id_imm = 0;
    Read_data1 = 0; Read_data2 = 0;
    ex_result = 0;
    mem_RegWrite = 0; mem_Write_register = 0;
    mem_result = 0;
    wb_RegWrite = 0; wb_Write_register = 0;
    wb_Write_data = 0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] wr,
                        input logic rw, input logic mr,
                        input logic [31:0] d1, input logic [31:0] d2);
    id_valid = v; id_rs = rs; id_rt = rt;
    id_Write_register = wr;
    id_RegWrite = rw; id_MemRead = mr;
    Read_data1 = d1; Read_data2 = d2;
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    #1;
    check(tag, {31'b0, stall}, {31'b0, exp});
  endtask

  // queue the expectation, clock once, then compare
  task automatic step(input string tag, input logic v,
                      input logic rw, input logic mr,
                      input logic [4:0] wr,
                      input logic [31:0] op1, input logic [31:0] op2,
                      input logic [15:0] cnt);
    exp_t e;
    e.tag = tag; e.v = v; e.rw = rw; e.mr = mr;
    e.wr = wr; e.op1 = op1; e.op2 = op2; e.cnt = cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".valid"}, {31'b0, ex_valid}, {31'b0, e.v});
      check({e.tag, ".rw"}, {31'b0, ex_RegWrite}, {31'b0, e.rw});
      check({e.tag, ".mr"}, {31'b0, ex_MemRead}, {31'b0, e.mr});
      check({e.tag, ".wr"}, {27'b0, ex_Write_register}, {27'b0, e.wr});
      check({e.tag, ".op1"}, ex_op1, e.op1);
      check({e.tag, ".op2"}, ex_op2, e.op2);
      check({e.tag, ".cnt"}, {16'b0, stall_count}, {16'b0, e.cnt});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1;
    step("reset", 0, 0, 0, 0, 0, 0, 0);
    check("reset.ctrl", {16'b0, ex_ctrl}, 32'h0);
    check("reset.imm", ex_imm, 32'h0);
    chk_stall("reset.stall", 0);
    reset = 0;

    // plain load, then ALU chain through ex_result
    set_id(1, 3, 7, 3, 1, 0, 32'h5, 32'h77);
    id_ctrl = 16'h1234; id_imm = 32'hDEADBEEF;
    step("load", 1, 1, 0, 3, 32'h5, 32'h77, 0);
    check("load.ctrl", {16'b0, ex_ctrl}, 32'h1234);
    check("load.imm", ex_imm, 32'hDEADBEEF);
    check("load.rs", {27'b0, ex_rs}, 32'd3);
    check("load.rt", {27'b0, ex_rt}, 32'd7);
    ex_result = 32'h10;
    set_id(1, 3, 8, 4, 1, 0, 32'h5, 32'h9);
    step("alu_chain", 1, 1, 0, 4, 32'h10, 32'h9, 0);

    // forwarding priority on $4
    ex_result = 32'h1;
    mem_RegWrite = 1; mem_Write_register = 4; mem_result = 32'h2;
    wb_RegWrite = 1; wb_Write_register = 4; wb_Write_data = 32'h3;
    set_id(1, 4, 4, 4, 0, 0, 32'h55, 32'h55);
    step("prio_ex", 1, 0, 0, 4, 32'h1, 32'h1, 0);
    step("prio_mem", 1, 0, 0, 4, 32'h2, 32'h2, 0);
    mem_RegWrite = 0;
    step("prio_wb", 1, 0, 0, 4, 32'h3, 32'h3, 0);
    wb_RegWrite = 0;

    // $0 never forwards, even from a $0 writer in EX
    set_id(1, 5, 6, 0, 1, 0, 32'hA, 32'hB);
    step("wr0_load", 1, 1, 0, 0, 32'hA, 32'hB, 0);
    ex_result = 32'h99;
    mem_RegWrite = 1; mem_Write_register = 0; mem_result = 32'h2;
    wb_RegWrite = 1; wb_Write_register = 0; wb_Write_data = 32'h3;
    set_id(1, 0, 0, 6, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step("zero_src", 1, 0, 0, 6, 32'h0, 32'h0, 0);
    idle();

    // load-use: one bubble, then data via mem_result
    set_id(1, 1, 0, 2, 1, 1, 32'h100, 32'h0);
    step("lw", 1, 1, 1, 2, 32'h100, 32'h0, 0);
    set_id(1, 2, 9, 5, 1, 0, 32'h0, 32'h9);
    chk_stall("lu.stall1", 1);
    step("lu_bubble", 0, 0, 0, 0, 0, 0, 1);
    chk_stall("lu.stall0", 0);
    mem_RegWrite = 1; mem_Write_register = 2; mem_result = 32'hAB;
    step("lu_mem", 1, 1, 0, 5, 32'hAB, 32'h9, 1);
    mem_RegWrite = 0;

    // flush beats hold and stall
    set_id(1, 1, 0, 2, 1, 1, 32'h100, 32'h0);
    step("lw2", 1, 1, 1, 2, 32'h100, 32'h0, 1);
    set_id(1, 2, 9, 5, 1, 0, 32'h0, 32'h9);
    flush = 1; hold = 1;
    chk_stall("flush.stall", 0);
    step("flush_hold", 0, 0, 0, 0, 0, 0, 1);
    flush = 0; hold = 0;

    // hold freezes contents
    set_id(1, 3, 4, 7, 1, 0, 32'h42, 32'h43);
    step("pre_hold", 1, 1, 0, 7, 32'h42, 32'h43, 1);
    hold = 1;
    set_id(1, 5, 6, 9, 0, 0, 32'h77, 32'h78);
    step("hold", 1, 1, 0, 7, 32'h42, 32'h43, 1);
    hold = 0;

    // hold with a pending stall does not count
    set_id(1, 1, 0, 2, 1, 1, 32'h100, 32'h0);
    step("lw3", 1, 1, 1, 2, 32'h100, 32'h0, 1);
    hold = 1;
    set_id(1, 2, 9, 5, 1, 0, 32'h0, 32'h9);
    chk_stall("hold.stall", 1);
    step("hold_stall", 1, 1, 1, 2, 32'h100, 32'h0, 1);

    // reset overrides hold and stall
    reset = 1;
    step("reset_hold", 0, 0, 0, 0, 0, 0, 0);
    check("rst.ctrl", {16'b0, ex_ctrl}, 32'h0);
    check("rst.rs", {27'b0, ex_rs}, 32'h0);
    chk_stall("rst.stall", 0);
    idle();

    // saturation of the stall counter
    @(negedge clk);
    force dut.stall_cnt = 16'hFFFE;
    #1;
    release dut.stall_cnt;
    set_id(1, 1, 0, 2, 1, 1, 32'h100, 32'h0);
    step("sat_lw1", 1, 1, 1, 2, 32'h100, 32'h0, 16'hFFFE);
    set_id(1, 2, 9, 5, 1, 0, 32'h0, 32'h9);
    step("sat_st1", 0, 0, 0, 0, 0, 0, 16'hFFFF);
    set_id(1, 1, 0, 2, 1, 1, 32'h100, 32'h0);
    step("sat_lw2", 1, 1, 1, 2, 32'h100, 32'h0, 16'hFFFF);
    set_id(1, 2, 9, 5, 1, 0, 32'h0, 32'h9);
    step("sat_st2", 0, 0, 0, 0, 0, 0, 16'hFFFF);

    // invalid ID gates control bits
    set_id(0, 7, 8, 3, 1, 1, 32'h1, 32'h2);
    step("invalid", 0, 0, 0, 3, 32'h1, 32'h2, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
